// File: rtl/clkdiv_pkg.sv
// Shared constants, state encoding and window-bound helpers for the divider-select decoder.
package clkdiv_pkg;

    localparam int TAP0_DEFAULT = 22;

    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    typedef struct packed {
        logic       fast;
        logic       slow;
        logic [1:0] cls;
    } class_t;

    // Lower bound of class s window: 0.75 * P0 * 2^s
    function automatic logic [35:0] win_lo(input int tap0, input int s);
        return 36'(3) << (tap0 + s - 1);
    endfunction

    // Upper (exclusive) bound of class s window: 1.5 * P0 * 2^s
    function automatic logic [35:0] win_hi(input int tap0, input int s);
        return 36'(3) << (tap0 + s);
    endfunction

endpackage

// File: rtl/clkdiv_sel_decoder_sync.sv
// Two-flop synchronizer for the divided clock plus a rising-edge detector.
module sync_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);
    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= sig_in;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/clkdiv_sel_decoder.sv
// Measures the period of a divided clock, classifies it into one of four divider
// taps, and locks sel_out after two consecutive matching measurements.
module clkdiv_sel_decoder
    import clkdiv_pkg::*;
#(
    parameter  int TAP0 = TAP0_DEFAULT,
    localparam int W    = TAP0 + 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    output logic [1:0]   sel_out,
    output logic         valid,
    output logic         err_fast,
    output logic         err_slow,
    output logic         meas_done,
    output logic [W-1:0] period
);
    localparam longint         P0  = longint'(1) << (TAP0 + 1);
    localparam logic [W-1:0]   LO0 = W'(win_lo(TAP0, 0));
    localparam logic [W-1:0]   HI0 = W'(win_hi(TAP0, 0));
    localparam logic [W-1:0]   HI1 = W'(win_hi(TAP0, 1));
    localparam logic [W-1:0]   HI2 = W'(win_hi(TAP0, 2));
    localparam logic [W-1:0]   HI3 = W'(win_hi(TAP0, 3));
    // Last count value before a missing edge is declared a timeout (1.5 * P3 - 1)
    localparam logic [W-1:0]   TMO = W'(12 * P0 - 1);

    function automatic class_t classify(input logic [W-1:0] p);
        class_t c;
        c = '0;
        if (p < LO0)      c.fast = 1'b1;
        else if (p < HI0) c.cls  = 2'd0;
        else if (p < HI1) c.cls  = 2'd1;
        else if (p < HI2) c.cls  = 2'd2;
        else if (p < HI3) c.cls  = 2'd3;
        else              c.slow = 1'b1;
        return c;
    endfunction

    logic         rise;
    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] period_nxt;
    class_t       cls_nxt;
    logic         have_match;
    logic [1:0]   last_cls;

    sync_rise_det u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise)
    );

    assign period_nxt = cnt + W'(1);
    assign cls_nxt    = classify(period_nxt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_EDGE;
            cnt        <= '0;
            period     <= '0;
            meas_done  <= 1'b0;
            err_fast   <= 1'b0;
            err_slow   <= 1'b0;
            valid      <= 1'b0;
            sel_out    <= 2'd0;
            have_match <= 1'b0;
            last_cls   <= 2'd0;
        end else begin
            meas_done <= 1'b0;
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= '0;
                    end
                end
                MEASURE: begin
                    // An edge on the timeout cycle wins and is measured as SLOW
                    if (rise) begin
                        period    <= period_nxt;
                        meas_done <= 1'b1;
                        cnt       <= '0;
                        err_fast  <= cls_nxt.fast;
                        err_slow  <= cls_nxt.slow;
                        if (cls_nxt.fast || cls_nxt.slow) begin
                            valid      <= 1'b0;
                            have_match <= 1'b0;
                        end else if (have_match && (cls_nxt.cls == last_cls)) begin
                            valid   <= 1'b1;
                            sel_out <= cls_nxt.cls;
                        end else begin
                            valid      <= 1'b0;
                            have_match <= 1'b1;
                            last_cls   <= cls_nxt.cls;
                        end
                    end else if (cnt == TMO) begin
                        state      <= WAIT_EDGE;
                        cnt        <= '0;
                        err_slow   <= 1'b1;
                        err_fast   <= 1'b0;
                        valid      <= 1'b0;
                        have_match <= 1'b0;
                    end else begin
                        cnt <= cnt + W'(1);
                    end
                end
                default: state <= WAIT_EDGE;
            endcase
        end
    end

endmodule
